// File: rtl/fpu_cvt.sv
// fpu_cvt: iterative int32<->float32 converter, round toward zero, one bit shift per cycle
module fpu_cvt (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        op_i,
    input  logic [31:0] a_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] result_o,
    output logic        invalid_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state;
    logic        op;
    logic        sgn;
    logic [31:0] mag;
    logic [7:0]  ex;
    logic [4:0]  cnt;
    logic [7:0]  e_in;
    logic [22:0] m_in;
    logic [31:0] a_abs;
    logic [31:0] sat;
    assign e_in = a_i[30:23];
    assign m_in = a_i[22:0];
    assign a_abs = a_i[31] ? -a_i : a_i;
    assign sat = a_i[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    assign req_ready_o = (state == IDLE);
    assign resp_valid_o = (state == DONE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            result_o  <= '0;
            invalid_o <= 1'b0;
            op        <= 1'b0;
            sgn       <= 1'b0;
            mag       <= '0;
            ex        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    op        <= op_i;
                    sgn       <= a_i[31];
                    invalid_o <= 1'b0;
                    if (!op_i) begin
                        mag <= a_abs;
                        ex  <= 8'd158;
                        if (a_i == '0) begin
                            result_o <= '0;
                            state    <= DONE;
                        end else
                            state <= SHIFT;
                    end else if (e_in == 8'hFF) begin
                        result_o  <= (m_in != '0) ? 32'h7FFF_FFFF : sat;
                        invalid_o <= 1'b1;
                        state     <= DONE;
                    end else if (e_in < 8'd127) begin
                        result_o <= '0;
                        state    <= DONE;
                    end else if (e_in >= 8'd158) begin
                        // -2^31 is the only exactly representable value at this exponent
                        result_o  <= sat;
                        invalid_o <= !(a_i[31] && e_in == 8'd158 && m_in == '0);
                        state     <= DONE;
                    end else begin
                        mag   <= {1'b1, m_in, 8'b0};
                        cnt   <= 5'(8'd158 - e_in);
                        state <= SHIFT;
                    end
                end
                SHIFT: if (!op) begin
                    if (!mag[31]) begin
                        mag <= mag << 1;
                        ex  <= ex - 8'd1;
                    end else begin
                        result_o <= {sgn, ex, mag[30:8]};
                        state    <= DONE;
                    end
                end else if (cnt != '0) begin
                    mag <= mag >> 1;
                    cnt <= cnt - 5'd1;
                end else begin
                    result_o  <= sgn ? -mag : mag;
                    invalid_o <= 1'b0;
                    state     <= DONE;
                end
                DONE: if (resp_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_cvt.sv
// tb_fpu_cvt: directed vectors for fpu_cvt with hand-computed results and latencies
module tb_fpu_cvt;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        op_i = 1'b0;
    logic [31:0] a_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        invalid_o;
    int total = 0;
    int bad = 0;

    fpu_cvt dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_i(op_i), .a_i(a_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .result_o(result_o), .invalid_o(invalid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic o, input logic [31:0] a, input logic [31:0] er,
                       input logic ei, input int el, input int hold);
        int lat;
        logic [31:0] snap;
        chk("ready_idle", 32'(req_ready_o), 32'd1);
        op_i = o;
        a_i = a;
        req_valid_i = 1'b1;
        resp_ready_i = (hold == 0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        a_i = ~a;
        op_i = ~o;
        lat = 1;
        while (!resp_valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_valid", 32'(resp_valid_o), 32'd1);
        chk("result", result_o, er);
        chk("invalid", 32'(invalid_o), 32'(ei));
        chk("latency", 32'(lat), 32'(el));
        snap = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_result", result_o, snap);
            chk("hold_valid", 32'(resp_valid_o), 32'd1);
            chk("hold_ready", 32'(req_ready_o), 32'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", 32'(resp_valid_o), 32'd0);
        chk("ready_back", 32'(req_ready_o), 32'd1);
        resp_ready_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_invalid", 32'(invalid_o), 32'd0);
        run(1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33, 0);
        run(1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33, 0);
        run(1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2, 0);
        run(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 0);
        run(1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b0, 9, 0);
        run(1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b0, 3, 0);
        run(1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 32, 0);
        run(1'b1, 32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 32, 0);
        run(1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1, 0);
        run(1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1, 0);
        run(1'b1, 32'hFF80_0000, 32'h8000_0000, 1'b1, 1, 0);
        run(1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1, 0);
        run(1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1, 0);
        run(1'b1, 32'h4049_0FDB, 32'h0000_0003, 1'b0, 32, 10);
        run(1'b1, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1, 3);
        op_i = 1'b0;
        a_i = 32'h0000_0001;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(req_ready_o), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        chk("abort_valid", 32'(resp_valid_o), 32'd0);
        chk("abort_result", result_o, 32'h0);
        chk("abort_invalid", 32'(invalid_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_resp", 32'(resp_valid_o), 32'd0);
        run(1'b1, 32'h3F80_0000, 32'h0000_0001, 1'b0, 33, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
